// File: rtl/game_rom_loader.sv
// -----------------------------------------------------------------------------
// game_rom_loader
// Receives an iNES image one byte at a time from the SoC game-ROM conduit.
// It validates the 16-byte header, then routes the PRG and CHR payload bytes
// onto the PRG and CHR memory write ports. The NES core is held in reset
// until the whole image has been written.
//
// Ports
//   clk, reset            sole clock; synchronous active-high reset
//   write_rom             level strobe; each rising edge is one byte write
//   rom_addr, to_game_rom iNES file offset and byte value of the write
//   prg_we/addr/data      PRG memory write port (15-bit address)
//   chr_we/addr/data      CHR memory write port (13-bit address)
//   prg_32k               1 = 32 KB PRG, 0 = 16 KB PRG
//   mirroring, mapper     header flags latched when the header is accepted
//   loaded                image fully written and valid
//   header_err            header rejected
//   hold_nes_reset        NES core held in reset while 1
// -----------------------------------------------------------------------------
module game_rom_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_rom,
    input  logic [15:0] rom_addr,
    input  logic [7:0]  to_game_rom,
    output logic        prg_we,
    output logic [14:0] prg_addr,
    output logic [7:0]  prg_data,
    output logic        chr_we,
    output logic [12:0] chr_addr,
    output logic [7:0]  chr_data,
    output logic        prg_32k,
    output logic        mirroring,
    output logic [7:0]  mapper,
    output logic        loaded,
    output logic        header_err,
    output logic        hold_nes_reset
);

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_BODY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t      state_r;
    logic        write_rom_q_r;
    logic [7:0]  hdr_r [16];
    logic [16:0] prg_end_r;
    logic [16:0] chr_end_r;

    logic        strobe_s;
    logic [16:0] addr_ext_s;
    logic [16:0] new_prg_end_s;
    logic [16:0] new_chr_end_s;
    logic        hdr_ok_s;
    logic        in_prg_s;
    logic        in_chr_s;
    logic        last_s;

    // Header acceptance: iNES magic, 16 or 32 KB PRG, 0 or 8 KB CHR.
    function automatic logic hdr_valid(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3,
        input logic [7:0] b4,
        input logic [7:0] b5
    );
        return (b0 == 8'h4E) && (b1 == 8'h45) && (b2 == 8'h53) && (b3 == 8'h1A)
            && ((b4 == 8'd1) || (b4 == 8'd2))
            && ((b5 == 8'd0) || (b5 == 8'd1));
    endfunction

    // Edge detect, region bounds and body routing decode.
    always_comb begin
        strobe_s      = write_rom & ~write_rom_q_r;
        addr_ext_s    = {1'b0, rom_addr};
        // byte4 is 1 or 2 once accepted, so only its low bits scale 16 KB units.
        new_prg_end_s = 17'd16 + {1'b0, hdr_r[4][1:0], 14'd0};
        new_chr_end_s = new_prg_end_s + {3'b000, hdr_r[5][0], 13'd0};
        hdr_ok_s      = hdr_valid(hdr_r[0], hdr_r[1], hdr_r[2], hdr_r[3], hdr_r[4], hdr_r[5]);
        in_prg_s      = (addr_ext_s >= 17'd16) && (addr_ext_s < prg_end_r);
        in_chr_s      = (addr_ext_s >= prg_end_r) && (addr_ext_s < chr_end_r);
        last_s        = (addr_ext_s == (chr_end_r - 17'd1));
    end

    // Loader FSM with registered write ports and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_HDR;
            write_rom_q_r  <= 1'b0;
            prg_we         <= 1'b0;
            prg_addr       <= 15'd0;
            prg_data       <= 8'd0;
            chr_we         <= 1'b0;
            chr_addr       <= 13'd0;
            chr_data       <= 8'd0;
            prg_32k        <= 1'b0;
            mirroring      <= 1'b0;
            mapper         <= 8'd0;
            loaded         <= 1'b0;
            header_err     <= 1'b0;
            hold_nes_reset <= 1'b1;
            prg_end_r      <= 17'd0;
            chr_end_r      <= 17'd0;
            for (int i = 0; i < 16; i++) begin
                hdr_r[i] <= 8'd0;
            end
        end else begin
            write_rom_q_r <= write_rom;
            prg_we        <= 1'b0;
            chr_we        <= 1'b0;
            if (strobe_s && (rom_addr == 16'd0)) begin
                // Offset 0 restarts the load from any state.
                state_r        <= ST_HDR;
                loaded         <= 1'b0;
                header_err     <= 1'b0;
                hold_nes_reset <= 1'b1;
                hdr_r[0]       <= to_game_rom;
            end else begin
                hold_nes_reset <= (state_r != ST_DONE);
                // DONE is entered in the we cycle, so loaded follows one cycle later.
                if (state_r == ST_DONE) begin
                    loaded <= 1'b1;
                end
                if (strobe_s) begin
                    case (state_r)
                        ST_HDR: begin
                            if (rom_addr < 16'd16) begin
                                hdr_r[rom_addr[3:0]] <= to_game_rom;
                                if (rom_addr == 16'd15) begin
                                    if (hdr_ok_s) begin
                                        state_r   <= ST_BODY;
                                        prg_32k   <= (hdr_r[4] == 8'd2);
                                        mirroring <= hdr_r[6][0];
                                        mapper    <= {hdr_r[7][7:4], hdr_r[6][7:4]};
                                        prg_end_r <= new_prg_end_s;
                                        chr_end_r <= new_chr_end_s;
                                    end else begin
                                        state_r    <= ST_ERR;
                                        header_err <= 1'b1;
                                    end
                                end
                            end
                        end
                        ST_BODY: begin
                            if (in_prg_s) begin
                                prg_we   <= 1'b1;
                                prg_addr <= rom_addr[14:0] - 15'd16;
                                prg_data <= to_game_rom;
                            end else if (in_chr_s) begin
                                chr_we   <= 1'b1;
                                // prg_end_r low 13 bits are always 16.
                                chr_addr <= rom_addr[12:0] - prg_end_r[12:0];
                                chr_data <= to_game_rom;
                            end
                            if ((in_prg_s || in_chr_s) && last_s) begin
                                state_r <= ST_DONE;
                            end
                        end
                        default: begin
                            // DONE and ERR ignore everything but offset 0.
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_game_rom_loader.sv
module tb_game_rom_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_rom;
    logic [15:0] rom_addr;
    logic [7:0]  to_game_rom;
    logic        prg_we;
    logic [14:0] prg_addr;
    logic [7:0]  prg_data;
    logic        chr_we;
    logic [12:0] chr_addr;
    logic [7:0]  chr_data;
    logic        prg_32k;
    logic        mirroring;
    logic [7:0]  mapper;
    logic        loaded;
    logic        header_err;
    logic        hold_nes_reset;

    int vectors = 0;
    int errors  = 0;

    // values captured in the cycle right after a write strobe
    logic        s_prg_we, s_chr_we, s_loaded;
    logic [14:0] s_prg_addr;
    logic [12:0] s_chr_addr;
    logic [7:0]  s_prg_data, s_chr_data;

    always #5 clk = ~clk;

    game_rom_loader dut (
        .clk            (clk),
        .reset          (reset),
        .write_rom      (write_rom),
        .rom_addr       (rom_addr),
        .to_game_rom    (to_game_rom),
        .prg_we         (prg_we),
        .prg_addr       (prg_addr),
        .prg_data       (prg_data),
        .chr_we         (chr_we),
        .chr_addr       (chr_addr),
        .chr_data       (chr_data),
        .prg_32k        (prg_32k),
        .mirroring      (mirroring),
        .mapper         (mapper),
        .loaded         (loaded),
        .header_err     (header_err),
        .hold_nes_reset (hold_nes_reset)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One write: rising edge, snapshot the we cycle, drop the level, one idle cycle.
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        rom_addr    = a;
        to_game_rom = d;
        write_rom   = 1'b1;
        @(negedge clk);
        s_prg_we   = prg_we;
        s_chr_we   = chr_we;
        s_prg_addr = prg_addr;
        s_chr_addr = chr_addr;
        s_prg_data = prg_data;
        s_chr_data = chr_data;
        s_loaded   = loaded;
        write_rom  = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_hdr(input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                            input logic [7:0] b6, input logic [7:0] b7);
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            case (i)
                0:       d = 8'h4E;
                1:       d = 8'h45;
                2:       d = 8'h53;
                3:       d = b3;
                4:       d = b4;
                5:       d = b5;
                6:       d = b6;
                7:       d = b7;
                default: d = 8'h00;
            endcase
            wr(16'(i), d);
        end
    endtask

    initial begin
        int pulses;
        reset       = 1'b1;
        write_rom   = 1'b0;
        rom_addr    = 16'd0;
        to_game_rom = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_prg_we", 32'(prg_we), 32'd0);
        chk("rst_chr_we", 32'(chr_we), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_hdr_err", 32'(header_err), 32'd0);
        chk("rst_hold", 32'(hold_nes_reset), 32'd1);
        chk("rst_mapper", 32'(mapper), 32'd0);
        chk("rst_prg32k", 32'(prg_32k), 32'd0);
        chk("rst_mirr", 32'(mirroring), 32'd0);

        // 32 KB PRG + 8 KB CHR, vertical mirroring, mapper 0
        load_hdr(8'h1A, 8'h02, 8'h01, 8'h01, 8'h00);
        chk("a_hdr_err", 32'(header_err), 32'd0);
        chk("a_prg32k", 32'(prg_32k), 32'd1);
        chk("a_mirr", 32'(mirroring), 32'd1);
        chk("a_mapper", 32'(mapper), 32'h00);
        chk("a_hold", 32'(hold_nes_reset), 32'd1);
        wr(16'd16, 8'h10);
        chk("a_prg0_we", 32'(s_prg_we), 32'd1);
        chk("a_prg0_chrwe", 32'(s_chr_we), 32'd0);
        chk("a_prg0_addr", 32'(s_prg_addr), 32'h0000);
        chk("a_prg0_data", 32'(s_prg_data), 32'h10);
        chk("a_prg0_we_after", 32'(prg_we), 32'd0);
        wr(16'd32783, 8'h0F);
        chk("a_prgtop_we", 32'(s_prg_we), 32'd1);
        chk("a_prgtop_addr", 32'(s_prg_addr), 32'h7FFF);
        wr(16'd32784, 8'h10);
        chk("a_chr0_we", 32'(s_chr_we), 32'd1);
        chk("a_chr0_prgwe", 32'(s_prg_we), 32'd0);
        chk("a_chr0_addr", 32'(s_chr_addr), 32'h0000);
        chk("a_chr0_data", 32'(s_chr_data), 32'h10);
        chk("a_loaded_early", 32'(loaded), 32'd0);
        wr(16'd40975, 8'h0F);
        chk("a_chrtop_we", 32'(s_chr_we), 32'd1);
        chk("a_chrtop_addr", 32'(s_chr_addr), 32'h1FFF);
        chk("a_loaded_wecycle", 32'(s_loaded), 32'd0);
        chk("a_loaded", 32'(loaded), 32'd1);
        chk("a_hold_done", 32'(hold_nes_reset), 32'd0);
        wr(16'd100, 8'h55);
        chk("a_done_ign_prg", 32'(s_prg_we), 32'd0);
        chk("a_done_ign_chr", 32'(s_chr_we), 32'd0);
        chk("a_done_hold_ld", 32'(loaded), 32'd1);

        // 16 KB PRG, no CHR, mapper 0x21
        wr(16'd0, 8'h4E);
        chk("b_reload_ld", 32'(loaded), 32'd0);
        chk("b_reload_hold", 32'(hold_nes_reset), 32'd1);
        load_hdr(8'h1A, 8'h01, 8'h00, 8'h10, 8'h20);
        chk("b_mapper", 32'(mapper), 32'h21);
        chk("b_prg32k", 32'(prg_32k), 32'd0);
        chk("b_mirr", 32'(mirroring), 32'd0);
        wr(16'd16400, 8'h77);
        chk("b_beyond_prg", 32'(s_prg_we), 32'd0);
        chk("b_beyond_chr", 32'(s_chr_we), 32'd0);
        wr(16'd16399, 8'h99);
        chk("b_last_we", 32'(s_prg_we), 32'd1);
        chk("b_last_addr", 32'(s_prg_addr), 32'h3FFF);
        chk("b_last_data", 32'(s_prg_data), 32'h99);
        chk("b_loaded", 32'(loaded), 32'd1);
        wr(16'd16400, 8'h77);
        chk("b_post_prg", 32'(s_prg_we), 32'd0);
        chk("b_post_chr", 32'(s_chr_we), 32'd0);

        // bad magic byte
        load_hdr(8'h1B, 8'h01, 8'h00, 8'h00, 8'h00);
        chk("c_hdr_err", 32'(header_err), 32'd1);
        chk("c_loaded", 32'(loaded), 32'd0);
        chk("c_hold", 32'(hold_nes_reset), 32'd1);
        wr(16'd16, 8'h33);
        chk("c_body_prg", 32'(s_prg_we), 32'd0);
        chk("c_body_chr", 32'(s_chr_we), 32'd0);
        wr(16'd0, 8'h4E);
        chk("c_err_clear", 32'(header_err), 32'd0);

        // unsupported PRG size
        load_hdr(8'h1A, 8'h03, 8'h00, 8'h00, 8'h00);
        chk("d_prg3_err", 32'(header_err), 32'd1);

        // level held high for 10 cycles
        load_hdr(8'h1A, 8'h01, 8'h00, 8'h11, 8'h00);
        chk("e_mapper", 32'(mapper), 32'h01);
        chk("e_mirr", 32'(mirroring), 32'd1);
        @(negedge clk);
        rom_addr    = 16'd20;
        to_game_rom = 8'hAB;
        write_rom   = 1'b1;
        pulses      = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (prg_we) pulses++;
            if (i == 0) begin
                chk("e_first_we", 32'(prg_we), 32'd1);
                chk("e_first_addr", 32'(prg_addr), 32'h0004);
            end
        end
        chk("e_pulse_count", 32'(pulses), 32'd1);
        write_rom = 1'b0;
        @(negedge clk);

        // reset mid-body, with a fresh edge arriving in the same cycle
        rom_addr    = 16'd30;
        to_game_rom = 8'hCD;
        write_rom   = 1'b1;
        reset       = 1'b1;
        @(negedge clk);
        chk("f_rst_prgwe", 32'(prg_we), 32'd0);
        chk("f_rst_prgaddr", 32'(prg_addr), 32'd0);
        chk("f_rst_prgdata", 32'(prg_data), 32'd0);
        chk("f_rst_mapper", 32'(mapper), 32'd0);
        chk("f_rst_mirr", 32'(mirroring), 32'd0);
        chk("f_rst_hold", 32'(hold_nes_reset), 32'd1);
        chk("f_rst_loaded", 32'(loaded), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("f_post_rst_we", 32'(prg_we), 32'd0);
        write_rom = 1'b0;
        @(negedge clk);
        wr(16'd16, 8'h44);
        chk("f_abort_we", 32'(s_prg_we), 32'd0);
        load_hdr(8'h1A, 8'h01, 8'h01, 8'h00, 8'h00);
        wr(16'd24591, 8'h5A);
        chk("f_chrtop_we", 32'(s_chr_we), 32'd1);
        chk("f_chrtop_addr", 32'(s_chr_addr), 32'h1FFF);
        chk("f_reload_loaded", 32'(loaded), 32'd1);
        chk("f_reload_hold", 32'(hold_nes_reset), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/game_rom_loader.md
GAME_ROM_LOADER -- requirements
Module: game_rom_loader

Interface
REQ-001 Clk  in  1  sole clock; all state on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 write_rom  in  1  level strobe from SoC game-ROM conduit; each 0->1 transition is one byte write.
REQ-004 rom_addr  in  16  iNES file byte offset of the write.
REQ-005 to_game_rom  in  8  byte value of the write.
REQ-006 prg_we / prg_addr / prg_data  out  1/15/8  PRG memory write port.
REQ-007 chr_we / chr_addr / chr_data  out  1/13/8  CHR memory write port.
REQ-008 prg_32k  out  1  PRG size: 1 = 32 KB, 0 = 16 KB.
REQ-009 mirroring  out  1  iNES flags6 bit0.
REQ-010 mapper  out  8  {flags7[7:4], flags6[7:4]}.
REQ-011 loaded  out  1  image fully written and valid.
REQ-012 header_err  out  1  header rejected.
REQ-013 hold_nes_reset  out  1  NES core held in reset while 1.

Function
REQ-014 Write detect: write_rom registered once; strobe = write_rom & ~write_rom_q; rom_addr and to_game_rom sampled in the strobe cycle.
REQ-015 Level held high produces exactly one write; back-to-back strobes no closer than 2 cycles apart (inherent to edge detect).
REQ-016 FSM states: HDR, BODY, DONE, ERR.
REQ-017 Any strobe with rom_addr == 0, in any state: next state HDR; loaded, header_err cleared; byte 0 processed as header.
REQ-018 HDR: bytes at offsets 0..15 stored into a 16-byte header register; strobes at offsets >15 ignored.
REQ-019 HDR exit on strobe at offset 15: magic bytes 0..3 == 4E 45 53 1A AND PRG units (byte4) in {1,2} AND CHR units (byte5) in {0,1} -> BODY; else -> ERR with header_err = 1.
REQ-020 On HDR->BODY: prg_32k = (byte4 == 2); mirroring, mapper latched; PRG_END = 16 + 16384*byte4; CHR_END = PRG_END + 8192*byte5 (17-bit arithmetic, max 40976).
REQ-021 BODY routing, offset a: 16 <= a < PRG_END -> prg_addr = a-16 (low 15 bits); PRG_END <= a < CHR_END -> chr_addr = a-PRG_END (low 13 bits); otherwise dropped, no we.
REQ-022 Write latency: strobe in cycle N -> prg_we or chr_we = 1 in cycle N+1 only, with addr/data stable that cycle; never both we asserted.
REQ-023 BODY -> DONE on the routed strobe at offset CHR_END-1 (equals PRG_END-1 when byte5 == 0); loaded = 1 from the cycle after that write's we pulse onward.
REQ-024 Writes need not be sequential; completion is triggered solely by the final-offset write.
REQ-025 DONE and ERR: all strobes except offset 0 ignored; outputs hold.
REQ-026 hold_nes_reset = 1 in every state except DONE.

Reset
REQ-027 On Reset: state HDR; prg_we, chr_we, prg_addr, chr_addr, prg_data, chr_data, prg_32k, mirroring, mapper, loaded, header_err = 0; hold_nes_reset = 1; header register and write_rom_q = 0.
REQ-028 Reset mid-BODY aborts the load; no we pulse in the cycle after Reset deasserts even if write_rom is high (write_rom_q cleared, so a held-high level does count as one new edge then).

Verification
REQ-029 Header 4E 45 53 1A 02 01 01 00 + 8 zeros, then offsets 16..40975 = a[7:0] -> 32768 prg_we pulses (prg_addr 0..7FFF), 8192 chr_we pulses; loaded = 1, prg_32k = 1, mirroring = 1, mapper = 00, hold_nes_reset = 0.
REQ-030 Header bytes 4..5 = 01 00, flags6 = 0x10, flags7 = 0x20 -> PRG_END = 16400; write to offset 16399 -> DONE; mapper = 0x21; write to offset 16400 yields no we.
REQ-031 Byte 3 = 0x1B -> after offset 15: header_err = 1, loaded = 0; subsequent body writes produce no we; new offset-0 write clears header_err.
REQ-032 Byte4 = 3 -> header_err = 1.
REQ-033 write_rom held high 10 cycles -> exactly one we pulse, one cycle after the rising edge.
REQ-034 Reset asserted mid-BODY -> all outputs return to REQ-027 values next cycle; reload from offset 0 completes normally.
